// File: rtl/stopwatch_lap_recorder.sv
// Lap snapshot memory and recall display mux for the stopwatch digits.
// Captures on LAP press, steps through stored laps on RECALL press.
module stopwatch_lap_recorder #(
  parameter int DEPTH = 8,
  parameter int IDX_W = 3,
  parameter int CNT_W = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             LAP_BTN,
  input  logic             RECALL_BTN,
  input  logic             CLR,
  input  logic [3:0]       IN_HOUR,
  input  logic [2:0]       IN_MINHIGH,
  input  logic [3:0]       IN_MINLOW,
  input  logic [2:0]       IN_SECHIGH,
  input  logic [3:0]       IN_SECLOW,
  input  logic [3:0]       IN_MSEC2ND,
  input  logic [3:0]       IN_MSEC1ST,
  input  logic [3:0]       IN_MSE00,
  output logic [3:0]       OUT_HOUR,
  output logic [2:0]       OUT_MINHIGH,
  output logic [3:0]       OUT_MINLOW,
  output logic [2:0]       OUT_SECHIGH,
  output logic [3:0]       OUT_SECLOW,
  output logic [3:0]       OUT_MSEC2ND,
  output logic [3:0]       OUT_MSEC1ST,
  output logic [3:0]       OUT_MSE00,
  output logic             RECALL_MODE,
  output logic [IDX_W-1:0] LAP_IDX,
  output logic [CNT_W-1:0] LAP_COUNT,
  output logic             FULL,
  output logic             OVF
);

  typedef enum logic {LIVE, RECALL} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [IDX_W-1:0] rd_idx, idx_n;
  logic             ovf_n;
  logic             we;
  logic             lap_d, recall_d;
  logic             lap_press, recall_press;
  logic             full;
  logic             last_lap;
  logic [29:0]      in_word;
  logic [29:0]      out_word;
  logic [29:0]      mem [DEPTH];

  assign in_word = {IN_HOUR, IN_MINHIGH, IN_MINLOW, IN_SECHIGH,
                    IN_SECLOW, IN_MSEC2ND, IN_MSEC1ST, IN_MSE00};

  assign lap_press    = LAP_BTN & ~lap_d;
  assign recall_press = RECALL_BTN & ~recall_d;
  assign full         = (cnt == CNT_W'(DEPTH));
  assign last_lap     = ((CNT_W'(rd_idx) + CNT_W'(1)) == cnt);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= LIVE;
      cnt      <= '0;
      rd_idx   <= '0;
      OVF      <= 1'b0;
      lap_d    <= 1'b1;
      recall_d <= 1'b1;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      rd_idx   <= idx_n;
      OVF      <= ovf_n;
      lap_d    <= LAP_BTN;
      recall_d <= RECALL_BTN;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = rd_idx;
    ovf_n   = 1'b0;
    we      = 1'b0;
    if (CLR) begin
      state_n = LIVE;
      cnt_n   = '0;
      idx_n   = '0;
    end else begin
      unique case (state)
        LIVE: begin
          if (recall_press) begin
            if (cnt != '0) begin
              state_n = RECALL;
              idx_n   = '0;
            end
          end else if (lap_press) begin
            if (full) begin
              ovf_n = 1'b1;
            end else begin
              we    = 1'b1;
              cnt_n = cnt + CNT_W'(1);
            end
          end
        end
        RECALL: begin
          if (recall_press) begin
            if (last_lap) begin
              state_n = LIVE;
              idx_n   = '0;
            end else begin
              idx_n = rd_idx + IDX_W'(1);
            end
          end
        end
      endcase
    end
  end

  // Memory carries no reset; its contents are meaningless until written.
  always_ff @(posedge CLK) begin
    if (we) begin
      mem[cnt[IDX_W-1:0]] <= in_word;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      out_word <= '0;
    end else if (state == RECALL) begin
      out_word <= mem[rd_idx];
    end else begin
      out_word <= in_word;
    end
  end

  assign {OUT_HOUR, OUT_MINHIGH, OUT_MINLOW, OUT_SECHIGH,
          OUT_SECLOW, OUT_MSEC2ND, OUT_MSEC1ST, OUT_MSE00} = out_word;

  assign RECALL_MODE = (state == RECALL);
  assign LAP_IDX     = rd_idx;
  assign LAP_COUNT   = cnt;
  assign FULL        = full;

endmodule

// File: tb/tb_stopwatch_lap_recorder.sv
// Directed bench for stopwatch_lap_recorder.
// Linear stimulus with hand-computed expectations.
module tb_stopwatch_lap_recorder;

  logic        clk = 1'b0;
  logic        rst, lap_btn, recall_btn, clr;
  logic [29:0] in_w;
  logic [3:0]  o_hour, o_ml, o_sl, o_m2, o_m1, o_m0;
  logic [2:0]  o_mh, o_sh;
  logic        recall_mode, full, ovf;
  logic [2:0]  lap_idx;
  logic [3:0]  lap_count;
  logic [29:0] out_w;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  stopwatch_lap_recorder dut (
    .CLK(clk), .RST(rst),
    .LAP_BTN(lap_btn), .RECALL_BTN(recall_btn), .CLR(clr),
    .IN_HOUR(in_w[29:26]), .IN_MINHIGH(in_w[25:23]),
    .IN_MINLOW(in_w[22:19]), .IN_SECHIGH(in_w[18:16]),
    .IN_SECLOW(in_w[15:12]), .IN_MSEC2ND(in_w[11:8]),
    .IN_MSEC1ST(in_w[7:4]), .IN_MSE00(in_w[3:0]),
    .OUT_HOUR(o_hour), .OUT_MINHIGH(o_mh), .OUT_MINLOW(o_ml),
    .OUT_SECHIGH(o_sh), .OUT_SECLOW(o_sl), .OUT_MSEC2ND(o_m2),
    .OUT_MSEC1ST(o_m1), .OUT_MSE00(o_m0),
    .RECALL_MODE(recall_mode), .LAP_IDX(lap_idx),
    .LAP_COUNT(lap_count), .FULL(full), .OVF(ovf)
  );

  assign out_w = {o_hour, o_mh, o_ml, o_sh, o_sl, o_m2, o_m1, o_m0};

  function automatic logic [29:0] mk(
    input logic [3:0] h, input logic [2:0] mh, input logic [3:0] ml,
    input logic [2:0] sh, input logic [3:0] sl, input logic [3:0] a,
    input logic [3:0] b, input logic [3:0] c);
    return {h, mh, ml, sh, sl, a, b, c};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [29:0] w1, w2, w3, wx;

  initial begin
    w1 = mk(0, 0, 1, 2, 3, 4, 5, 6);
    w2 = mk(0, 0, 2, 0, 5, 7, 8, 9);
    w3 = mk(1, 3, 4, 5, 6, 1, 2, 3);
    rst = 1'b1; lap_btn = 1'b1; recall_btn = 1'b0; clr = 1'b0;
    in_w = mk(1, 1, 1, 1, 1, 1, 1, 1);
    step(); step(); step();
    chk("rst_out", 32'(out_w), 0);
    chk("rst_cnt", 32'(lap_count), 0);
    chk("rst_mode", 32'(recall_mode), 0);
    chk("rst_ovf", 32'(ovf), 0);

    // Release reset with LAP held: no capture
    rst = 1'b0;
    step();
    chk("held_lap_cnt", 32'(lap_count), 0);
    chk("live_out0", 32'(out_w), 32'(mk(1, 1, 1, 1, 1, 1, 1, 1)));
    lap_btn = 1'b0;
    in_w = w3;
    chk("live_lag", 32'(out_w), 32'(mk(1, 1, 1, 1, 1, 1, 1, 1)));
    step();
    chk("live_out1", 32'(out_w), 32'(w3));
    chk("held_lap_cnt2", 32'(lap_count), 0);

    // Two laps
    in_w = w1; lap_btn = 1'b1; step();
    lap_btn = 1'b0; step();
    chk("lap1_cnt", 32'(lap_count), 1);
    in_w = w2; lap_btn = 1'b1; step();
    lap_btn = 1'b0; step();
    chk("lap2_cnt", 32'(lap_count), 2);
    in_w = w3;

    recall_btn = 1'b1; step();
    chk("rc0_mode", 32'(recall_mode), 1);
    chk("rc0_idx", 32'(lap_idx), 0);
    chk("rc0_out_live", 32'(out_w), 32'(w3));
    step();
    chk("rc0_out", 32'(out_w), 32'(w1));
    recall_btn = 1'b0; step();
    recall_btn = 1'b1; step();
    chk("rc1_idx", 32'(lap_idx), 1);
    step();
    chk("rc1_out", 32'(out_w), 32'(w2));
    chk("rc1_mode", 32'(recall_mode), 1);
    recall_btn = 1'b0; step();
    recall_btn = 1'b1; step();
    chk("rc2_mode", 32'(recall_mode), 0);
    chk("rc2_idx", 32'(lap_idx), 0);
    step();
    chk("rc2_out", 32'(out_w), 32'(w3));
    recall_btn = 1'b0; step();

    // LAP during RECALL is ignored, then CLR
    recall_btn = 1'b1; step();
    recall_btn = 1'b0;
    lap_btn = 1'b1; step();
    chk("rlap_cnt", 32'(lap_count), 2);
    chk("rlap_ovf", 32'(ovf), 0);
    chk("rlap_mode", 32'(recall_mode), 1);
    lap_btn = 1'b0;
    clr = 1'b1; step();
    clr = 1'b0;
    chk("clr_mode", 32'(recall_mode), 0);
    chk("clr_cnt", 32'(lap_count), 0);
    chk("clr_full", 32'(full), 0);

    // RECALL with no laps stays LIVE
    recall_btn = 1'b1; step();
    chk("empty_rc_mode", 32'(recall_mode), 0);
    recall_btn = 1'b0; step();

    // Nine laps into eight entries
    for (int i = 0; i < 9; i++) begin
      in_w = mk(0, 0, 0, 0, 4'(i), 0, 0, 4'(i + 1));
      lap_btn = 1'b1; step();
      chk("fill_ovf", 32'(ovf), (i == 8) ? 1 : 0);
      lap_btn = 1'b0; step();
      chk("fill_ovf_clr", 32'(ovf), 0);
    end
    chk("fill_cnt", 32'(lap_count), 8);
    chk("fill_full", 32'(full), 1);
    in_w = w3;
    recall_btn = 1'b1; step();
    for (int i = 1; i < 8; i++) begin
      recall_btn = 1'b0; step();
      recall_btn = 1'b1; step();
    end
    chk("rc7_idx", 32'(lap_idx), 7);
    step();
    wx = mk(0, 0, 0, 0, 7, 0, 0, 8);
    chk("rc7_out", 32'(out_w), 32'(wx));
    recall_btn = 1'b0; step();
    recall_btn = 1'b1; step();
    chk("rc7_exit", 32'(recall_mode), 0);
    recall_btn = 1'b0;
    clr = 1'b1; step();
    clr = 1'b0;

    // Held LAP gives exactly one capture
    in_w = w1;
    lap_btn = 1'b1; step(); step(); step();
    chk("hold_cnt", 32'(lap_count), 1);
    lap_btn = 1'b0; step();

    // Simultaneous LAP and RECALL with one lap stored
    lap_btn = 1'b1; recall_btn = 1'b1; step();
    chk("both_mode", 32'(recall_mode), 1);
    chk("both_idx", 32'(lap_idx), 0);
    chk("both_cnt", 32'(lap_count), 1);
    step();
    chk("both_out", 32'(out_w), 32'(w1));
    lap_btn = 1'b0; recall_btn = 1'b0; step();
    recall_btn = 1'b1; step();
    chk("both_exit", 32'(recall_mode), 0);
    recall_btn = 1'b0; step();

    // Same stimulus with CLR
    lap_btn = 1'b1; recall_btn = 1'b1; clr = 1'b1; step();
    chk("bclr_cnt", 32'(lap_count), 0);
    chk("bclr_mode", 32'(recall_mode), 0);
    clr = 1'b0; step();
    chk("bclr_held_cnt", 32'(lap_count), 0);
    chk("bclr_held_mode", 32'(recall_mode), 0);
    lap_btn = 1'b0; recall_btn = 1'b0; step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
